// File: rtl/cpu_instr_fetch.sv
// cpu_instr_fetch: 6502 instruction fetch stage feeding the execute (IE) stage.
// Reads the opcode and operand bytes one at a time, starting at RESET_PC. It decodes
// the instruction length from the opcode and hands IE a complete bundle over valid/ready.
// Ports:
//   i_clk, i_rst           clock (rising edge), synchronous active-low reset
//   o_mem_addr, o_mem_rd_en read request to CPU memory; data returns one cycle later
//   i_mem_rd_data          read data byte
//   o_instr_valid/i_instr_ready  bundle handshake towards IE
//   o_instr_opcode/_operand/_len/_pc  instruction bundle
//   i_redirect_en/i_redirect_pc  fetch restart request from IE
module cpu_instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0200
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd_en,
    input  logic [7:0]  i_mem_rd_data,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [7:0]  o_instr_opcode,
    output logic [15:0] o_instr_operand,
    output logic [1:0]  o_instr_len,
    output logic [15:0] o_instr_pc,
    input  logic        i_redirect_en,
    input  logic [15:0] i_redirect_pc
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 2;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_W-1:0]     r_pc;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_opcode;
    logic [2*DATA_W-1:0]   r_operand;
    logic [LEN_W-1:0]      r_len;
    logic [ADDR_W-1:0]     r_instr_pc;
    logic [LEN_W-1:0]      w_dec_len;
    logic [LEN_W-1:0]      w_cur_len;
    logic                  w_last_byte;
    logic                  w_redirect;

    // Instruction length from the aaabbbcc opcode fields.
    function automatic logic [LEN_W-1:0] decode_len(input logic [DATA_W-1:0] op);
        logic [1:0] cc;
        logic [2:0] bbb;
        cc  = op[1:0];
        bbb = op[4:2];
        decode_len = LEN_W'(2);
        if (cc == 2'b11) begin
            decode_len = LEN_W'(1);
        end else if (cc == 2'b01) begin
            decode_len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? LEN_W'(3) : LEN_W'(2);
        end else begin
            case (bbb)
                3'b000: begin
                    if (op == 8'h20)
                        decode_len = LEN_W'(3);
                    else if (op == 8'h00 || op == 8'h40 || op == 8'h60)
                        decode_len = LEN_W'(1);
                    else
                        decode_len = LEN_W'(2);
                end
                3'b001, 3'b100, 3'b101: decode_len = LEN_W'(2);
                3'b010, 3'b110:         decode_len = LEN_W'(1);
                default:                decode_len = LEN_W'(3);
            endcase
        end
    endfunction

    // While capturing the opcode the length is not registered yet, so use the live decode.
    always_comb begin
        w_dec_len   = decode_len(i_mem_rd_data);
        w_cur_len   = (r_idx == '0) ? w_dec_len : r_len;
        w_last_byte = (3'(r_idx) + 3'd1) >= 3'(w_cur_len);
        w_redirect  = i_redirect_en && (r_state != ST_START);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) r_state <= ST_START;
        else        r_state <= w_next_state;
    end

    // Next-state logic; a redirect overrides everything outside START.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_START:   w_next_state = ST_ISSUE;
            ST_ISSUE:   w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = w_last_byte ? ST_OUT : ST_ISSUE;
            ST_OUT:     if (i_instr_ready) w_next_state = ST_ISSUE;
            default:    w_next_state = ST_START;
        endcase
        if (w_redirect) w_next_state = ST_ISSUE;
    end

    // Outputs decoded from state and datapath registers.
    always_comb begin
        o_mem_rd_en     = (r_state == ST_ISSUE);
        o_mem_addr      = (r_state == ST_ISSUE) ? r_pc : '0;
        o_instr_valid   = (r_state == ST_OUT);
        o_instr_opcode  = r_opcode;
        o_instr_operand = r_operand;
        o_instr_len     = r_len;
        o_instr_pc      = r_instr_pc;
    end

    // Fetch datapath: pc, byte slot index and the instruction bundle.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pc       <= RESET_PC;
            r_idx      <= '0;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_len      <= '0;
            r_instr_pc <= '0;
        end else if (w_redirect) begin
            r_pc      <= i_redirect_pc;
            r_idx     <= '0;
            r_operand <= '0;
        end else begin
            case (r_state)
                ST_CAPTURE: begin
                    r_pc  <= r_pc + ADDR_W'(1);
                    r_idx <= r_idx + IDX_W'(1);
                    case (r_idx)
                        2'd0: begin
                            r_opcode   <= i_mem_rd_data;
                            r_instr_pc <= r_pc;
                            r_len      <= w_dec_len;
                        end
                        2'd1:    r_operand[DATA_W-1:0]        <= i_mem_rd_data;
                        default: r_operand[2*DATA_W-1:DATA_W] <= i_mem_rd_data;
                    endcase
                end
                ST_OUT: begin
                    if (i_instr_ready) begin
                        r_operand <= '0;
                        r_idx     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_instr_fetch.sv
// Bench for cpu_instr_fetch: a memory model answers reads one cycle late, the stimulus
// process pushes expected bundles into a scoreboard queue, and a monitor compares
// every accepted bundle plus the per-cycle protocol rules (reset values, hold while
// stalled, fetch address after a handshake or redirect, first-bundle latency).
module tb_cpu_instr_fetch;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] opd;
        logic [1:0]  len;
        logic [15:0] pc;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_data = 8'h00;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;

    logic [7:0]  mem [0:65535];
    bundle_t     exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        done  = 1'b0;

    always #5 clk = ~clk;

    cpu_instr_fetch #(.RESET_PC(16'h0200)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .o_mem_addr      (mem_addr),
        .o_mem_rd_en     (mem_rd_en),
        .i_mem_rd_data   (mem_rd_data),
        .o_instr_valid   (instr_valid),
        .i_instr_ready   (instr_ready),
        .o_instr_opcode  (instr_opcode),
        .o_instr_operand (instr_operand),
        .o_instr_len     (instr_len),
        .o_instr_pc      (instr_pc),
        .i_redirect_en   (redirect_en),
        .i_redirect_pc   (redirect_pc)
    );

    // Memory: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
        else           mem_rd_data <= 8'($urandom);
    end

    // Reference length rule, written as opcode-class membership.
    function automatic int ref_len(input logic [7:0] op);
        logic [2:0] bbb;
        bbb = op[4:2];
        if (op[1:0] == 2'b11) return 1;
        if (op[1:0] == 2'b01) return (bbb inside {3'b011, 3'b110, 3'b111}) ? 3 : 2;
        if (op == 8'h20) return 3;
        if (op inside {8'h00, 8'h40, 8'h60}) return 1;
        if (bbb inside {3'b010, 3'b110}) return 1;
        if (bbb inside {3'b011, 3'b111}) return 3;
        return 2;
    endfunction

    function automatic bundle_t mk(input logic [7:0] op, input logic [15:0] opd,
                                   input logic [1:0] len, input logic [15:0] pc);
        bundle_t b;
        b.op = op; b.opd = opd; b.len = len; b.pc = pc;
        return b;
    endfunction

    // The instruction that lives at pc in the current memory image.
    function automatic bundle_t ref_instr(input logic [15:0] pc);
        bundle_t b;
        int l;
        logic [15:0] a1, a2;
        a1 = pc + 16'd1;
        a2 = pc + 16'd2;
        l  = ref_len(mem[pc]);
        b.op  = mem[pc];
        b.len = 2'(l);
        b.pc  = pc;
        b.opd = 16'h0000;
        if (l >= 2) b.opd[7:0]  = mem[a1];
        if (l == 3) b.opd[15:8] = mem[a2];
        return b;
    endfunction

    task automatic push_stream(input logic [15:0] start, input int n);
        logic [15:0] p;
        bundle_t b;
        p = start;
        for (int i = 0; i < n; i++) begin
            b = ref_instr(p);
            exp_q.push_back(b);
            p = p + 16'(b.len);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        instr_ready = 1'b0;
        redirect_en = 1'b0;
        rst = 1'b0;
        repeat (2) step();
    endtask

    // Offer ready until the scoreboard is empty; ready drops as soon as it is.
    task automatic drain(input bit rand_ready);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            instr_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            step();
            c++;
        end
        instr_ready = 1'b0;
        if (c >= 3000) begin
            $display("FAIL drain: %0d bundles still expected after %0d cycles", exp_q.size(), c);
            $fatal(1);
        end
    endtask

    task automatic wait_valid();
        int c;
        c = 0;
        while (!instr_valid && c < 100) begin
            step();
            c++;
        end
        if (c >= 100) begin
            $display("FAIL wait_valid: instr_valid=%0b, required 1 within 100 cycles", instr_valid);
            $fatal(1);
        end
    endtask

    // Monitor / scoreboard.
    logic    p_rst = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_redir = 1'b0;
    logic [15:0] p_rpc = 16'h0;
    bundle_t p_bundle = '0;
    int      since_rel = 0;
    logic    lat_done = 1'b0, redir_seen = 1'b0;
    int      stall = 0;

    always @(negedge clk) begin
        bundle_t cur, e;
        logic [15:0] nxt;
        int exp_lat;
        cur = {instr_opcode, instr_operand, instr_len, instr_pc};

        if (!p_rst) begin
            n_cmp++;
            if ({mem_rd_en, mem_addr, instr_valid, cur} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: rd_en=%0b addr=%h valid=%0b bundle=%h, required all 0",
                         mem_rd_en, mem_addr, instr_valid, cur);
            end
        end else if (p_redir) begin
            n_cmp++;
            if (instr_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== p_rpc) begin
                n_err++;
                $display("FAIL redirect_issue: valid=%0b rd_en=%0b addr=%h, required 0/1/%h",
                         instr_valid, mem_rd_en, mem_addr, p_rpc);
            end
        end else if (p_valid && p_ready) begin
            nxt = p_bundle.pc + 16'(p_bundle.len);
            n_cmp++;
            if (instr_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== nxt) begin
                n_err++;
                $display("FAIL next_issue: valid=%0b rd_en=%0b addr=%h, required 0/1/%h",
                         instr_valid, mem_rd_en, mem_addr, nxt);
            end
        end else if (p_valid) begin
            n_cmp++;
            if (instr_valid !== 1'b1 || cur !== p_bundle || mem_rd_en !== 1'b0) begin
                n_err++;
                $display("FAIL hold_stable: valid=%0b rd_en=%0b bundle=%h, required 1/0/%h",
                         instr_valid, mem_rd_en, cur, p_bundle);
            end
        end

        // First bundle after reset release: START plus two cycles per byte.
        if (!rst) begin
            since_rel = 0; lat_done = 1'b0; redir_seen = 1'b0;
        end else begin
            since_rel++;
            if (redirect_en) redir_seen = 1'b1;
            if (instr_valid && !lat_done) begin
                lat_done = 1'b1;
                if (!redir_seen) begin
                    exp_lat = 2 * ref_len(mem[16'h0200]) + 1;
                    n_cmp++;
                    if (since_rel - 1 != exp_lat) begin
                        n_err++;
                        $display("FAIL first_latency: %0d cycles, required %0d", since_rel - 1, exp_lat);
                    end
                end
            end
        end

        if (rst && instr_valid && instr_ready) begin
            stall = 0;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_bundle: got %h, none expected", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    n_err++;
                    $display("FAIL bundle: got op=%h opd=%h len=%0d pc=%h, required op=%h opd=%h len=%0d pc=%h",
                             cur.op, cur.opd, cur.len, cur.pc, e.op, e.opd, e.len, e.pc);
                end
            end
        end else if (exp_q.size() != 0) begin
            stall++;
            if (stall > 300) begin
                n_cmp++;
                n_err++;
                $display("FAIL bundle_timeout: %0d bundles outstanding, required 0 after 300 cycles", exp_q.size());
                exp_q.delete();
                stall = 0;
            end
        end

        if (done) begin
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_err++;
                $display("FAIL leftover: %0d bundles never delivered, required 0", exp_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
        end

        p_rst = rst; p_valid = instr_valid; p_ready = instr_ready;
        p_redir = redirect_en; p_rpc = redirect_pc; p_bundle = cur;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Stimulus.
    initial begin
        logic [15:0] p;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        repeat (3) step();

        // T1: mixed lengths, ready held high.
        mem[16'h0200] = 8'hA2; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h8A; mem[16'h0203] = 8'h18;
        exp_q.push_back(mk(8'hA2, 16'h0000, 2'd2, 16'h0200));
        exp_q.push_back(mk(8'h8A, 16'h0000, 2'd1, 16'h0202));
        exp_q.push_back(mk(8'h18, 16'h0000, 2'd1, 16'h0203));
        rst = 1'b1;
        drain(1'b0);

        // T2: three-byte instruction, seven-cycle latency.
        reset_dut();
        mem[16'h0200] = 8'h7D; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
        exp_q.push_back(mk(8'h7D, 16'h1234, 2'd3, 16'h0200));
        rst = 1'b1;
        drain(1'b0);

        // T3: IE stalls for five cycles.
        reset_dut();
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h05; mem[16'h0202] = 8'hE8;
        exp_q.push_back(mk(8'hA9, 16'h0005, 2'd2, 16'h0200));
        exp_q.push_back(mk(8'hE8, 16'h0000, 2'd1, 16'h0202));
        rst = 1'b1;
        wait_valid();
        repeat (5) step();
        drain(1'b0);

        // T4: redirect while capturing the low operand byte of AD.
        reset_dut();
        mem[16'h0200] = 8'hAD; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h03; mem[16'h0204] = 8'hEA;
        exp_q.push_back(mk(8'hEA, 16'h0000, 2'd1, 16'h0204));
        rst = 1'b1;
        for (int c = 0; c < 50 && !(mem_rd_en && mem_addr == 16'h0201); c++) step();
        step();
        redirect_en = 1'b1; redirect_pc = 16'h0204;
        step();
        redirect_en = 1'b0;
        drain(1'b0);

        // T5: operand fetch wraps past FFFF.
        mem[16'hFFFF] = 8'hAD; mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
        exp_q.push_back(mk(8'hAD, 16'h1234, 2'd3, 16'hFFFF));
        redirect_en = 1'b1; redirect_pc = 16'hFFFF;
        step();
        redirect_en = 1'b0;
        drain(1'b0);

        // Redirect in the same cycle as a completed handshake.
        push_stream(16'h0002, 1);
        wait_valid();
        instr_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 16'h0300;
        push_stream(16'h0300, 3);
        step();
        redirect_en = 1'b0;
        drain(1'b1);

        // T6: reset pulse while a bundle is waiting.
        reset_dut();
        mem[16'h0200] = 8'hA2; mem[16'h0201] = 8'h00; mem[16'h0202] = 8'h8A; mem[16'h0203] = 8'h18;
        rst = 1'b1;
        wait_valid();
        rst = 1'b0;
        step();
        rst = 1'b1;
        exp_q.push_back(mk(8'hA2, 16'h0000, 2'd2, 16'h0200));
        exp_q.push_back(mk(8'h8A, 16'h0000, 2'd1, 16'h0202));
        drain(1'b1);

        // Random redirects into random memory with random backpressure.
        for (int s = 0; s < 30; s++) begin
            p = 16'($urandom);
            push_stream(p, $urandom_range(1, 5));
            redirect_en = 1'b1; redirect_pc = p;
            step();
            redirect_en = 1'b0;
            drain(1'b1);
            repeat ($urandom_range(0, 8)) step();
        end

        done = 1'b1;
        forever step();
    end

endmodule
